rf_writeback_arbiter: RTL and testbench

RF_WRITEBACK_ARBITER -- requirements
Module: rf_writeback_arbiter

---
 rtl/rf_writeback_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_arbiter.sv
// Register-file writeback arbiter: pipeline port A over a 2-deep buffered port B, with starvation hold.
// Optional pending-destination scoreboard is compiled in with ZEPTRON_WB_SCOREBOARD_EN.
module rf_writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3,
  output logic        hold,
  output logic [31:0] busy,
  output logic        err
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rdMem_q   [2];
  logic [31:0]   dataMem_q [2];
  logic          wrPtr_q, rdPtr_q;
  logic [1:0]    fifoCnt_q, fifoCnt_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic          err_q, err_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;

  logic          fifoEmpty, fifoFull, aReq, grantA, grantB, push, issErr;
  logic [4:0]    headRd;
  logic [31:0]   headData;

  // Grant selection: A wins unless hold is up or it targets r0; otherwise drain the FIFO head.
  always_comb begin
    fifoEmpty = (fifoCnt_q == 2'd0);
    fifoFull  = (fifoCnt_q == 2'd2);
    headRd    = rdMem_q[rdPtr_q];
    headData  = dataMem_q[rdPtr_q];
    aReq      = a_valid && (a_rd != 5'd0);
    grantA    = !hold_q && aReq;
    grantB    = !grantA && !fifoEmpty;
    push      = b_valid && !fifoFull;
  end

  assign b_ready = !fifoFull;

  always_comb begin
    fifoCnt_d = fifoCnt_q;
    if (push && !grantB) begin
      fifoCnt_d = fifoCnt_q + 2'd1;
    end else if (!push && grantB) begin
      fifoCnt_d = fifoCnt_q - 2'd1;
    end
  end

  // Starvation: only A wins over a waiting B entry advance the count; hold fires once at the limit.
  always_comb begin
    starve_d = '0;
    if (grantA && !fifoEmpty) begin
      starve_d = starve_q + CW'(1);
    end
    hold_d = (starve_d == CW'(STARVE_LIMIT));
  end

  always_comb begin
    we3_d = 1'b0;
    wa3_d = wa3_q;
    wd3_d = wd3_q;
    if (grantA) begin
      we3_d = 1'b1;
      wa3_d = a_rd;
      wd3_d = a_data;
    end else if (grantB) begin
      we3_d = (headRd != 5'd0);
      wa3_d = headRd;
      wd3_d = headData;
    end
    err_d = err_q || (hold_q && aReq) || issErr;
  end

`ifdef ZEPTRON_WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;
  logic        issSet;

  // A new issue to a register wins over a same-cycle completion clearing it.
  always_comb begin
    issSet = iss_valid && (iss_rd != 5'd0);
    issErr = issSet && busy_q[iss_rd];
    busy_d = busy_q;
    if (grantB) begin
      busy_d[headRd] = 1'b0;
    end
    if (issSet) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  logic unusedIss;
  assign unusedIss = ^{iss_valid, iss_rd};
  assign issErr    = 1'b0;
  assign busy      = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        rdMem_q[i]   <= '0;
        dataMem_q[i] <= '0;
      end
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      fifoCnt_q <= '0;
    end else begin
      if (push) begin
        rdMem_q[wrPtr_q]   <= b_rd;
        dataMem_q[wrPtr_q] <= b_data;
        wrPtr_q            <= !wrPtr_q;
      end
      if (grantB) begin
        rdPtr_q <= !rdPtr_q;
      end
      fifoCnt_q <= fifoCnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
    end
  end

  assign we3  = we3_q;
  assign wa3  = wa3_q;
  assign wd3  = wd3_q;
  assign hold = hold_q;
  assign err  = err_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Self-checking bench for rf_writeback_arbiter: directed scenarios then random traffic vs. a queue model.
module tb_rf_writeback_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, iss_valid;
  logic [4:0]  a_rd, b_rd, iss_rd;
  logic [31:0] a_data, b_data;
  logic        b_ready, we3, hold, err;
  logic [4:0]  wa3;
  logic [31:0] wd3, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entT;

  entT         fifoM [$];
  int          starveM;
  bit          holdM, errM, weM;
  logic [4:0]  waM;
  logic [31:0] wdM;
  logic [31:0] busyM;

  always #5 clk = ~clk;

  rf_writeback_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .hold(hold), .busy(busy), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  task automatic modelReset();
    fifoM.delete();
    starveM = 0; holdM = 0; errM = 0; weM = 0; busyM = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_we3", 32'(we3), 32'd0);
    checkOutput("rst_wa3", 32'(wa3), 32'd0);
    checkOutput("rst_wd3", wd3, 32'd0);
    checkOutput("rst_hold", 32'(hold), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", busy, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idleInputs();
    reset = 1'b1;
    checkOutput("rel_b_ready", 32'(b_ready), 32'd1);
    checkOutput("rel_we3", 32'(we3), 32'd0);
  endtask

  // One clock of the reference model: arbitration rules applied to a queue, then compare after the edge.
  task automatic applyStimulus();
    bit  aReq, gA, gB;
    int  sizeBefore;
    entT head;
    sizeBefore = fifoM.size();
    checkOutput("b_ready", 32'(b_ready), 32'(sizeBefore < 2));
    aReq = a_valid && (a_rd != 0);
    gA   = !holdM && aReq;
    gB   = !gA && (sizeBefore > 0);
    if (holdM && aReq) errM = 1;
`ifdef ZEPTRON_WB_SCOREBOARD_EN
    if (iss_valid && iss_rd != 0 && busyM[iss_rd]) errM = 1;
`endif
    if (gA) begin
      weM = 1; waM = a_rd; wdM = a_data;
    end else if (gB) begin
      head = fifoM.pop_front();
      weM = (head.rd != 0); waM = head.rd; wdM = head.data;
    end else begin
      weM = 0;
    end
`ifdef ZEPTRON_WB_SCOREBOARD_EN
    if (gB) busyM[head.rd] = 1'b0;
    if (iss_valid && iss_rd != 0) busyM[iss_rd] = 1'b1;
    busyM[0] = 1'b0;
`endif
    starveM = (gA && sizeBefore > 0) ? starveM + 1 : 0;
    holdM   = (starveM == LIMIT);
    if (b_valid && sizeBefore < 2) fifoM.push_back('{rd: b_rd, data: b_data});
    @(posedge clk);
    #1;
    checkOutput("we3", 32'(we3), 32'(weM));
    if (weM) begin
      checkOutput("wa3", 32'(wa3), 32'(waM));
      checkOutput("wd3", wd3, wdM);
    end
    checkOutput("hold", 32'(hold), 32'(holdM));
    checkOutput("err", 32'(err), 32'(errM));
    checkOutput("busy", busy, busyM);
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();
    @(posedge clk);
    #1;
    doReset();

    // A-only write
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("A_we3", 32'(we3), 32'd1);
    checkOutput("A_wa3", 32'(wa3), 32'd5);
    checkOutput("A_wd3", wd3, 32'hDEADBEEF);
    idleInputs();
    applyStimulus();
    checkOutput("A_we3_off", 32'(we3), 32'd0);

    // single B push, two-cycle latency
    b_valid = 1; b_rd = 7; b_data = 32'h0000_0777;
    applyStimulus();
    checkOutput("B_lat_n1", 32'(we3), 32'd0);
    idleInputs();
    applyStimulus();
    checkOutput("B_lat_we3", 32'(we3), 32'd1);
    checkOutput("B_lat_wa3", 32'(wa3), 32'd7);
    applyStimulus();

    // three back-to-back B pushes while A occupies the port
    a_valid = 1; a_rd = 3; a_data = 32'h33;
    b_valid = 1; b_rd = 8; b_data = 32'h88;
    applyStimulus();
    b_rd = 10; b_data = 32'hAA;
    applyStimulus();
    b_rd = 13; b_data = 32'hDD;
    checkOutput("B3_ready", 32'(b_ready), 32'd0);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("B_order0", 32'(wa3), 32'd8);
    applyStimulus();
    checkOutput("B_order1", 32'(wa3), 32'd10);
    applyStimulus();
    checkOutput("B_drained", 32'(we3), 32'd0);

    // starvation hold, A during hold sets err
    a_valid = 1; a_rd = 3; a_data = 32'h3333;
    b_valid = 1; b_rd = 9; b_data = 32'h9999;
    applyStimulus();
    b_valid = 0;
    repeat (3) applyStimulus();
    checkOutput("hold_pre", 32'(hold), 32'd0);
    applyStimulus();
    checkOutput("hold_on", 32'(hold), 32'd1);
    applyStimulus();
    checkOutput("hold_wa3", 32'(wa3), 32'd9);
    checkOutput("hold_wd3", wd3, 32'h9999);
    checkOutput("hold_off", 32'(hold), 32'd0);
    checkOutput("err_set", 32'(err), 32'd1);
    a_valid = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("err_sticky", 32'(err), 32'd1);

    // A targeting r0 does not block B
    b_valid = 1; b_rd = 11; b_data = 32'hB11;
    applyStimulus();
    b_valid = 0; a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF;
    applyStimulus();
    checkOutput("r0_B_we3", 32'(we3), 32'd1);
    checkOutput("r0_B_wa3", 32'(wa3), 32'd11);
    idleInputs();
    applyStimulus();
    doReset();

`ifdef ZEPTRON_WB_SCOREBOARD_EN
    iss_valid = 1; iss_rd = 12;
    applyStimulus();
    iss_valid = 0;
    checkOutput("busy12_set", 32'(busy[12]), 32'd1);
    b_valid = 1; b_rd = 12; b_data = 32'hC12;
    applyStimulus();
    b_valid = 0; iss_valid = 1; iss_rd = 12;
    applyStimulus();
    checkOutput("busy12_setwins", 32'(busy[12]), 32'd1);
    iss_rd = 0;
    applyStimulus();
    checkOutput("busy_r0", busy, 32'h0000_1000);
    iss_valid = 0; b_valid = 1; b_rd = 12;
    applyStimulus();
    b_valid = 0;
    applyStimulus();
    checkOutput("busy12_clr", 32'(busy[12]), 32'd0);
`else
    iss_valid = 1; iss_rd = 12;
    applyStimulus();
    checkOutput("busy_tied", busy, 32'd0);
    iss_valid = 0;
`endif
    idleInputs();
    doReset();

    // reset with FIFO full and hold up
    a_valid = 1; a_rd = 3; a_data = 32'h3;
    b_valid = 1; b_rd = 20; b_data = 32'h20;
    applyStimulus();
    b_rd = 21; b_data = 32'h21;
    applyStimulus();
    b_valid = 0;
    repeat (3) applyStimulus();
    checkOutput("full_hold", 32'(hold), 32'd1);
    checkOutput("full_ready", 32'(b_ready), 32'd0);
    doReset();
    applyStimulus();
    checkOutput("no_stale0", 32'(we3), 32'd0);
    applyStimulus();
    checkOutput("no_stale1", 32'(we3), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      a_valid   = ($urandom_range(0, 9) < 6);
      a_rd      = 5'($urandom_range(0, 31));
      a_data    = $urandom;
      b_valid   = ($urandom_range(0, 9) < 5);
      b_rd      = 5'($urandom_range(0, 31));
      b_data    = $urandom;
      iss_valid = ($urandom_range(0, 9) < 2);
      iss_rd    = 5'($urandom_range(0, 31));
      applyStimulus();
      if (i == 200) begin
        idleInputs();
        doReset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
